// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and a
// counter-width helper.
// Imported by serial_adder (top) only; fa_cell is self-contained.
package serial_adder_pkg;

  // Encodings are fixed so waveforms and any external state decode stay stable.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Bit-position counter width; clamped to 1 so a degenerate WIDTH still elaborates.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit combinational full adder, the only arithmetic cell of the
// serial adder.
// Latency: combinational. Backpressure: none (pure function).
// Ports: a, b, ci (in, 1) -> s (sum, 1), co (carry out, 1).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  // Propagate term is shared between the sum and carry equations.
  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (w_p & ci);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder that pushes one bit pair per clock (LSB first)
// through a single fa_cell, carry held in a flip-flop between bits.
// Latency: done pulses in the cycle after accept edge E + WIDTH; a new start in
// that DONE cycle is accepted (back-to-back). start is ignored while busy.
// Ports:
//   clk, rst_n (async active-low), start (load request),
//   a, b [WIDTH], cin   : operands, sampled only on the accepting edge
//   busy                : high while bits are being shifted
//   done                : one-cycle pulse, sum/cout valid
//   sum [WIDTH], cout   : result, held until the next result is produced
//   ovf (only with SERIAL_ADDER_OVF_EN defined): two's-complement overflow,
//                         registered and held with sum.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;

  fa_cell u_fa (
    .a  (r_opa[0]),
    .b  (r_opb[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-edge control strobes.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_accept    = start;
        w_state_nxt = start ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        w_shift     = 1'b1;
        w_last      = (r_count == LAST_CNT);
        w_state_nxt = w_last ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        // Accepting here gives back-to-back operation with no idle bubble.
        w_accept    = start;
        w_state_nxt = start ? S_SHIFT : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand/sum shift registers, carry flip-flop, bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_sum_sr <= '0;
      r_count  <= '0;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_opa    <= a;
      r_opb    <= b;
      r_sum_sr <= '0;
      r_count  <= '0;
      r_carry  <= cin;
    end else if (w_shift) begin
      r_opa    <= {1'b0, r_opa[WIDTH-1:1]};
      r_opb    <= {1'b0, r_opb[WIDTH-1:1]};
      // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
      r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
      r_count  <= r_count + 1'b1;
      r_carry  <= w_co;
    end
  end

  // Registered outputs. busy/done are decoded from the next state so they line
  // up exactly with the SHIFT and DONE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_SHIFT);
      r_done <= (w_state_nxt == S_DONE);
      if (w_last) begin
        // The final bit is still in flight, so merge it here rather than
        // waiting for r_sum_sr to settle one cycle later.
        r_sum  <= {w_s, r_sum_sr[WIDTH-1:1]};
        r_cout <= w_co;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last shift r_carry is the carry into the MSB cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_co;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf4;
`endif

  int n_vec;
  int n_err;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation on the 8-bit instance. Returns with the bench sitting
  // at the negedge where done was first seen (or after a 20-cycle timeout).
  // lat counts negedges after the one following the accept edge; bcnt counts
  // negedges on which busy was high.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                      output int lat, output int bcnt);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (sum !== 8'h00) begin n_err++; $display("FAIL reset_sum got %h want 00", sum); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_zero();
    int lat, bcnt;
    run8(8'h00, 8'h00, 1'b0, lat, bcnt);
    n_vec++; if (lat != 8) begin n_err++; $display("FAIL zero_latency got %0d want 8", lat); end
    n_vec++; if (sum !== 8'h00 || cout !== 1'b0) begin
      n_err++; $display("FAIL zero_result got %b_%h want 0_00", cout, sum);
    end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_carry_chain();
    int lat, bcnt;
    run8(8'hFF, 8'h01, 1'b0, lat, bcnt);
    n_vec++; if (sum !== 8'h00 || cout !== 1'b1) begin
      n_err++; $display("FAIL ff_plus_1 got %b_%h want 1_00", cout, sum);
    end
    n_vec++; if (bcnt != 8) begin n_err++; $display("FAIL busy_cycles got %0d want 8", bcnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_at_done got %b want 0", busy); end
    // Result must be held once done drops.
    repeat (3) @(negedge clk);
    n_vec++; if (sum !== 8'h00 || cout !== 1'b1) begin
      n_err++; $display("FAIL hold_result got %b_%h want 1_00", cout, sum);
    end
  endtask

  task automatic test_mixed_cin();
    int lat, bcnt;
    run8(8'h3C, 8'h41, 1'b1, lat, bcnt);
    n_vec++; if (sum !== 8'h7E || cout !== 1'b0) begin
      n_err++; $display("FAIL mixed_cin got %b_%h want 0_7e", cout, sum);
    end
    run8(8'hC8, 8'h9B, 1'b0, lat, bcnt);
    n_vec++; if (sum !== 8'h63 || cout !== 1'b1) begin
      n_err++; $display("FAIL c8_plus_9b got %b_%h want 1_63", cout, sum);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run8(8'hA5, 8'h5A, 1'b1, lat, bcnt);
    n_vec++; if (sum !== 8'h00 || cout !== 1'b1) begin
      n_err++; $display("FAIL a5_5a_cin got %b_%h want 1_00", cout, sum);
    end
    // Still in the DONE cycle: request the next operation right away.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++; if (lat != 8) begin n_err++; $display("FAIL b2b_latency got %0d want 8", lat); end
    n_vec++; if (sum !== 8'h07 || cout !== 1'b0) begin
      n_err++; $display("FAIL b2b_result got %b_%h want 0_07", cout, sum);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_vec++; if (lat != 8) begin n_err++; $display("FAIL busy_start_latency got %0d want 8", lat); end
    n_vec++; if (sum !== 8'h30 || cout !== 1'b0) begin
      n_err++; $display("FAIL busy_start_ignored got %b_%h want 0_30", cout, sum);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midop_rst_ctrl got busy=%b done=%b want 0/0", busy, done);
    end
    n_vec++; if (sum !== 8'h00 || cout !== 1'b0) begin
      n_err++; $display("FAIL midop_rst_result got %b_%h want 0_00", cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_vec++; if (seen != 0) begin
      n_err++; $display("FAIL midop_rst_no_done got %0d active cycles want 0", seen);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    int lat, bcnt;
    run8(8'h7F, 8'h01, 1'b0, lat, bcnt);
    n_vec++; if (sum !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_7f_01 got c=%b s=%h v=%b want 0 80 1", cout, sum, ovf);
    end
    run8(8'hFF, 8'h01, 1'b0, lat, bcnt);
    n_vec++; if (sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_ff_01 got c=%b s=%h v=%b want 1 00 0", cout, sum, ovf);
    end
  endtask
`endif

  task automatic test_exhaustive4();
    int        n;
    logic [4:0] exp;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          n = 0;
          while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
          end
          exp = 5'(ia + ib + ic);
          n_vec++;
          if (n != 4 || {cout4, sum4} !== exp) begin
            n_err++;
            $display("FAIL w4 %0d+%0d+%0d got %h lat %0d want %h lat 4",
                     ia, ib, ic, {cout4, sum4}, n, exp);
          end
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_zero();
    test_carry_chain();
    test_mixed_cin();
    test_back_to_back();
    test_start_ignored();
    test_reset_midop();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    test_exhaustive4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_adder
